// File: rtl/dm_s2mm_burst_writer.sv
// dm_s2mm_burst_writer
//   S2MM write engine. Takes (addr, byte-length) commands, splits each one into
//   AXI4 INCR bursts of at most MAX_BURST beats and streams i_wr_data onto the
//   HP write port. Only one burst is outstanding at a time.
//   Optional macro: DMW_4K_SPLIT_EN - additionally split bursts at 4 KB boundaries.
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   i_wr_cmd_addr/length/req      command (req is a level, held until ack)
//   o_wr_cmd_ack                  1-cycle command-accept pulse
//   i_wr_valid/o_wr_ready/i_wr_data  write-data stream (pass-through in W)
//   o_write_finish                1-cycle pulse when the command's last BRESP arrives
//   o_wr_err                      sticky: any non-OKAY BRESP since reset
//   hp0_aw*/hp0_w*/hp0_b*         AXI4 write address/data/response channels
module dm_s2mm_burst_writer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 23,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   i_wr_cmd_addr,
    input  logic [LEN_WIDTH-1:0]    i_wr_cmd_length,
    input  logic                    i_wr_cmd_req,
    output logic                    o_wr_cmd_ack,
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_write_finish,
    output logic                    o_wr_err,
    output logic                    hp0_awvalid,
    input  logic                    hp0_awready,
    output logic [ID_WIDTH-1:0]     hp0_awid,
    output logic [ADDR_WIDTH-1:0]   hp0_awaddr,
    output logic [7:0]              hp0_awlen,
    output logic [2:0]              hp0_awsize,
    output logic [1:0]              hp0_awburst,
    output logic [2:0]              hp0_awprot,
    output logic [3:0]              hp0_awcache,
    output logic [DATA_WIDTH-1:0]   hp0_wdata,
    output logic [DATA_WIDTH/8-1:0] hp0_wstrb,
    output logic                    hp0_wlast,
    output logic                    hp0_wvalid,
    input  logic                    hp0_wready,
    input  logic [1:0]              hp0_bresp,
    input  logic                    hp0_bvalid,
    output logic                    hp0_bready
);

    localparam int unsigned BYTES   = DATA_WIDTH / 8;
    localparam int unsigned OFF_W   = $clog2(BYTES);
    localparam int unsigned BL_W    = LEN_WIDTH - OFF_W;
    localparam int unsigned BURST_W = $clog2(MAX_BURST) + 1;
    // Wide enough for beats_left, MAX_BURST and the 4 KB room term.
    localparam int unsigned CW      = (BL_W > 14) ? BL_W : 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BL_W-1:0]     beats_left_q, beats_left_d;
    logic [BURST_W-1:0]  cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [BL_W-1:0]     cmd_beats_c;
    logic [CW-1:0]       len_cap_c;
    logic [BURST_W-1:0]  burst_len_c;
    logic                last_beat_c;
`ifdef DMW_4K_SPLIT_EN
    logic [CW-1:0]       room_4k_c;
`endif

    // Constant AXI attributes
    assign hp0_awid    = ID_WIDTH'(AXI_ID);
    assign hp0_awsize  = 3'(OFF_W);
    assign hp0_awburst = 2'b01;
    assign hp0_awprot  = 3'b000;
    assign hp0_awcache = 4'b0011;
    assign hp0_wstrb   = '1;

    // Sub-beat length bits are dropped
    assign cmd_beats_c = BL_W'(i_wr_cmd_length >> OFF_W);

    // Current burst length; addr_q/beats_left_q only move on the last W beat,
    // so this stays stable through AW and W.
    always_comb begin
        len_cap_c = CW'(MAX_BURST);
        if (CW'(beats_left_q) < len_cap_c) begin
            len_cap_c = CW'(beats_left_q);
        end
`ifdef DMW_4K_SPLIT_EN
        room_4k_c = CW'((13'h1000 - {1'b0, addr_q[11:0]}) >> OFF_W);
        if (room_4k_c < len_cap_c) begin
            len_cap_c = room_4k_c;
        end
`endif
        burst_len_c = BURST_W'(len_cap_c);
    end

    assign last_beat_c = (cnt_q == burst_len_c - BURST_W'(1));

    // Next-state and outputs
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        beats_left_d   = beats_left_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        o_wr_cmd_ack   = 1'b0;
        o_wr_ready     = 1'b0;
        o_write_finish = 1'b0;
        o_wr_err       = err_q;
        hp0_awvalid    = 1'b0;
        hp0_awaddr     = addr_q;
        hp0_awlen      = '0;
        hp0_wdata      = '0;
        hp0_wlast      = 1'b0;
        hp0_wvalid     = 1'b0;
        hp0_bready     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_wr_cmd_req) begin
                    o_wr_cmd_ack = 1'b1;
                    addr_d       = i_wr_cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
                    beats_left_d = cmd_beats_c;
                    cnt_d        = '0;
                    state_d      = (cmd_beats_c != '0) ? S_AW : S_DONE;
                end
            end
            S_AW: begin
                hp0_awvalid = 1'b1;
                hp0_awlen   = 8'(burst_len_c - BURST_W'(1));
                if (hp0_awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                hp0_wvalid = i_wr_valid;
                o_wr_ready = hp0_wready;
                hp0_wdata  = i_wr_data;
                hp0_wlast  = last_beat_c;
                if (i_wr_valid && hp0_wready) begin
                    if (last_beat_c) begin
                        cnt_d        = '0;
                        addr_d       = addr_q + (ADDR_WIDTH'(burst_len_c) << OFF_W);
                        beats_left_d = beats_left_q - BL_W'(burst_len_c);
                        state_d      = S_B;
                    end else begin
                        cnt_d = cnt_q + BURST_W'(1);
                    end
                end
            end
            S_B: begin
                hp0_bready = 1'b1;
                if (hp0_bvalid) begin
                    // Error is recorded but the command keeps going
                    if (hp0_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    state_d = (beats_left_q != '0) ? S_AW : S_DONE;
                end
            end
            S_DONE: begin
                o_write_finish = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_dm_s2mm_burst_writer.sv
// Bench for dm_s2mm_burst_writer (DATA_WIDTH=64, MAX_BURST=16).
// A random AXI slave / stream producer runs on the falling edge; commands are
// checked against a burst-list reference model and a table of known results.
module tb_dm_s2mm_burst_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_wr_cmd_addr = '0;
    logic [22:0] i_wr_cmd_length = '0;
    logic        i_wr_cmd_req = 1'b0;
    logic        o_wr_cmd_ack;
    logic        i_wr_valid = 1'b0;
    logic        o_wr_ready;
    logic [63:0] i_wr_data = '0;
    logic        o_write_finish;
    logic        o_wr_err;
    logic        hp0_awvalid;
    logic        hp0_awready = 1'b0;
    logic [3:0]  hp0_awid;
    logic [31:0] hp0_awaddr;
    logic [7:0]  hp0_awlen;
    logic [2:0]  hp0_awsize;
    logic [1:0]  hp0_awburst;
    logic [2:0]  hp0_awprot;
    logic [3:0]  hp0_awcache;
    logic [63:0] hp0_wdata;
    logic [7:0]  hp0_wstrb;
    logic        hp0_wlast;
    logic        hp0_wvalid;
    logic        hp0_wready = 1'b0;
    logic [1:0]  hp0_bresp = 2'b00;
    logic        hp0_bvalid = 1'b0;
    logic        hp0_bready;

    dm_s2mm_burst_writer dut (
        .clk(clk), .rst(rst),
        .i_wr_cmd_addr(i_wr_cmd_addr), .i_wr_cmd_length(i_wr_cmd_length),
        .i_wr_cmd_req(i_wr_cmd_req), .o_wr_cmd_ack(o_wr_cmd_ack),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
        .o_write_finish(o_write_finish), .o_wr_err(o_wr_err),
        .hp0_awvalid(hp0_awvalid), .hp0_awready(hp0_awready), .hp0_awid(hp0_awid),
        .hp0_awaddr(hp0_awaddr), .hp0_awlen(hp0_awlen), .hp0_awsize(hp0_awsize),
        .hp0_awburst(hp0_awburst), .hp0_awprot(hp0_awprot), .hp0_awcache(hp0_awcache),
        .hp0_wdata(hp0_wdata), .hp0_wstrb(hp0_wstrb), .hp0_wlast(hp0_wlast),
        .hp0_wvalid(hp0_wvalid), .hp0_wready(hp0_wready),
        .hp0_bresp(hp0_bresp), .hp0_bvalid(hp0_bvalid), .hp0_bready(hp0_bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [22:0] len;
        int          err_b;   // burst index (within command) answered with SLVERR, -1 none
        int          n;       // expected burst count, -1 = use model only
        logic [31:0] a0;      // expected first awaddr
        int          l0;      // expected first awlen
        bit          err;     // expected o_wr_err after the command
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Bus-side records, written only by the bus process
    logic [31:0] obs_addr[$];
    int          obs_len[$];
    int          obs_beats[$];
    int          cur_beat = 0;
    int          b_n = 0;
    int          fin_cnt = 0;
    int          ack_cnt = 0;
    int          awv_cnt = 0;
    int          data_bad = 0;
    int          wlast_bad = 0;
    int          hs_bad = 0;
    bit          b_pending = 0;
    bit          s_hs = 0;
    bit          b_hs = 0;
    bit          adv = 0;
    logic [31:0] stream_ctr = '0;
    logic [31:0] exp_ctr = '0;

    // Written only by the main process
    int          err_burst = -1;
    logic [31:0] m_addr[$];
    int          m_len[$];
    vec_t        vecs[9];
    vec_t        rv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Random slave + stream producer + handshake monitor
    always @(negedge clk) begin
        adv = s_hs;
        if (adv) stream_ctr = stream_ctr + 32'd1;
        if (b_hs) begin
            hp0_bvalid = 1'b0;
            b_n++;
        end
        s_hs = 0;
        b_hs = 0;
        if (rst) begin
            hp0_awready = 1'b0;
            hp0_wready  = 1'b0;
            hp0_bvalid  = 1'b0;
            hp0_bresp   = 2'b00;
            i_wr_valid  = 1'b0;
            b_pending   = 0;
            cur_beat    = 0;
        end else begin
            if (adv || !i_wr_valid) i_wr_valid = ($urandom_range(0, 3) != 0);
            i_wr_data = {~stream_ctr, stream_ctr};
            if (b_pending && !hp0_bvalid && ($urandom_range(0, 2) != 0)) begin
                hp0_bvalid = 1'b1;
                hp0_bresp  = (b_n == err_burst) ? 2'b10 : 2'b00;
                b_pending  = 0;
            end
            hp0_awready = ($urandom_range(0, 3) != 0);
            hp0_wready  = ($urandom_range(0, 3) != 0);
            #1;
            if (hp0_awvalid) awv_cnt++;
            if (o_write_finish) fin_cnt++;
            if (o_wr_cmd_ack) ack_cnt++;
            if (hp0_awvalid && hp0_awready) begin
                obs_addr.push_back(hp0_awaddr);
                obs_len.push_back(int'(hp0_awlen));
                obs_beats.push_back(0);
                cur_beat = 0;
            end
            if ((i_wr_valid && o_wr_ready) != (hp0_wvalid && hp0_wready)) hs_bad++;
            if (o_wr_ready && !hp0_wready) hs_bad++;
            if (hp0_wvalid && hp0_wready) begin
                if (obs_len.size() == 0) begin
                    wlast_bad++;
                end else begin
                    if (hp0_wdata != {~exp_ctr, exp_ctr}) data_bad++;
                    if (hp0_wlast != (cur_beat == obs_len[obs_len.size()-1])) wlast_bad++;
                    obs_beats[obs_beats.size()-1]++;
                    cur_beat++;
                    if (cur_beat == obs_len[obs_len.size()-1] + 1) b_pending = 1;
                end
                exp_ctr = exp_ctr + 32'd1;
            end
            if (i_wr_valid && o_wr_ready) s_hs = 1;
            if (hp0_bvalid && hp0_bready) b_hs = 1;
        end
    end

    // Reference: burst list from the splitting rules
    task automatic build_model(input logic [31:0] addr, input logic [22:0] len);
        logic [31:0] a;
        int n;
        int l;
        m_addr.delete();
        m_len.delete();
        a = addr & 32'hFFFF_FFF8;
        n = int'(len >> 3);
        while (n > 0) begin
            l = (n < 16) ? n : 16;
`ifdef DMW_4K_SPLIT_EN
            if ((4096 - int'(a[11:0])) / 8 < l) l = (4096 - int'(a[11:0])) / 8;
`endif
            m_addr.push_back(a);
            m_len.push_back(l - 1);
            a = a + 32'(l * 8);
            n = n - l;
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int aw0, ack0, fin0, awv0, wl0, db0, hb0, k, nexp, nobs;
        build_model(v.addr, v.len);
        nexp = m_addr.size();
        aw0 = obs_addr.size(); ack0 = ack_cnt; fin0 = fin_cnt; awv0 = awv_cnt;
        wl0 = wlast_bad; db0 = data_bad; hb0 = hs_bad;
        err_burst = (v.err_b >= 0) ? b_n + v.err_b : -1;
        @(negedge clk);
        i_wr_cmd_addr = v.addr;
        i_wr_cmd_length = v.len;
        i_wr_cmd_req = 1'b1;
        #2;
        k = 0;
        while (!o_wr_cmd_ack && k < 20) begin @(negedge clk); #2; k++; end
        chk("ack_seen", o_wr_cmd_ack, 1);
        @(negedge clk);
        i_wr_cmd_req = 1'b0;
        #2;
        if (nexp > 0) chk("awvalid_cycle_after_ack", hp0_awvalid, 1);
        k = 1;
        while (!o_write_finish && k < 3000) begin @(negedge clk); #2; k++; end
        chk("finish_seen", o_write_finish, 1);
        if (nexp == 0) begin
            chk("zero_len_finish_within_2", (k <= 2), 1);
            chk("zero_len_no_awvalid", awv_cnt - awv0, 0);
        end
        @(negedge clk); #2;
        chk("finish_is_pulse", o_write_finish, 0);
        chk("finish_count", fin_cnt - fin0, 1);
        chk("ack_count", ack_cnt - ack0, 1);
        nobs = obs_addr.size() - aw0;
        chk("burst_count_model", nobs, nexp);
        if (v.n >= 0) chk("burst_count_table", nobs, v.n);
        if (v.n > 0 && nobs > 0) begin
            chk("first_awaddr_table", obs_addr[aw0], v.a0);
            chk("first_awlen_table", obs_len[aw0], v.l0);
        end
        for (int i = 0; i < nobs && i < nexp; i++) begin
            chk("awaddr_model", obs_addr[aw0+i], m_addr[i]);
            chk("awlen_model", obs_len[aw0+i], m_len[i]);
            chk("beats_in_burst", obs_beats[aw0+i], m_len[i] + 1);
        end
        chk("wlast_position", wlast_bad - wl0, 0);
        chk("wdata_order", data_bad - db0, 0);
        chk("stream_handshake", hs_bad - hb0, 0);
        chk("wr_err", o_wr_err, v.err);
    endtask

    initial begin
        int k, base;
        vecs[0] = '{32'h0000_1000, 23'd128,  -1, 1, 32'h0000_1000, 15, 1'b0};
        vecs[1] = '{32'h0000_0000, 23'd1024, -1, 8, 32'h0000_0000, 15, 1'b0};
`ifdef DMW_4K_SPLIT_EN
        vecs[2] = '{32'h0000_0FF0, 23'd64,   -1, 2, 32'h0000_0FF0, 1,  1'b0};
        vecs[6] = '{32'hFFFF_FFC0, 23'd128,  -1, 2, 32'hFFFF_FFC0, 7,  1'b0};
`else
        vecs[2] = '{32'h0000_0FF0, 23'd64,   -1, 1, 32'h0000_0FF0, 7,  1'b0};
        vecs[6] = '{32'hFFFF_FFC0, 23'd128,  -1, 1, 32'hFFFF_FFC0, 15, 1'b0};
`endif
        vecs[3] = '{32'h0000_4000, 23'd0,    -1, 0, 32'h0,         0,  1'b0};
        vecs[4] = '{32'h0000_1007, 23'd135,  -1, 1, 32'h0000_1000, 15, 1'b0};
        vecs[5] = '{32'h0000_3000, 23'd200,  -1, 2, 32'h0000_3000, 15, 1'b0};
        vecs[7] = '{32'h0000_5000, 23'd5,    -1, 0, 32'h0,         0,  1'b0};
        vecs[8] = '{32'h0000_0000, 23'd1024,  1, 8, 32'h0000_0000, 15, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        chk("rst_awvalid", hp0_awvalid, 0);
        chk("rst_wvalid", hp0_wvalid, 0);
        chk("rst_bready", hp0_bready, 0);
        chk("rst_wlast", hp0_wlast, 0);
        chk("rst_ack", o_wr_cmd_ack, 0);
        chk("rst_finish", o_write_finish, 0);
        chk("rst_err", o_wr_err, 0);
        chk("rst_wr_ready", o_wr_ready, 0);
        chk("rst_awaddr", hp0_awaddr, 0);
        chk("rst_awlen", hp0_awlen, 0);
        chk("rst_awsize", hp0_awsize, 3);
        chk("rst_awburst", hp0_awburst, 1);
        chk("rst_awcache", hp0_awcache, 3);
        chk("rst_awprot", hp0_awprot, 0);
        chk("rst_awid", hp0_awid, 0);
        chk("rst_wstrb", hp0_wstrb, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Random commands against the reference model
        for (int r = 0; r < 14; r++) begin
            rv.addr = $urandom;
            if (r % 2 == 0) rv.addr[11:0] = 12'(4096 - 8 * $urandom_range(0, 24));
            rv.addr[2:0] = 3'($urandom_range(0, 7));
            rv.len = 23'($urandom_range(0, 700));
            rv.err_b = -1; rv.n = -1; rv.a0 = '0; rv.l0 = 0; rv.err = 1'b0;
            run_cmd(rv);
        end

        // Directed table
        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // Error flag is sticky
        repeat (5) @(negedge clk);
        #2;
        chk("err_sticky", o_wr_err, 1);

        // Asynchronous reset in the middle of a W phase
        err_burst = -1;
        base = obs_addr.size();
        @(negedge clk);
        i_wr_cmd_addr = 32'h0;
        i_wr_cmd_length = 23'd1024;
        i_wr_cmd_req = 1'b1;
        #2;
        k = 0;
        while (!o_wr_cmd_ack && k < 20) begin @(negedge clk); #2; k++; end
        @(negedge clk);
        i_wr_cmd_req = 1'b0;
        #2;
        k = 0;
        while (!(obs_addr.size() >= base + 2 && obs_beats[obs_beats.size()-1] >= 2 &&
                 obs_beats[obs_beats.size()-1] <= 12) && k < 3000) begin
            @(negedge clk); #2; k++;
        end
        chk("reached_mid_w", (k < 3000), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_awvalid", hp0_awvalid, 0);
        chk("midrst_wvalid", hp0_wvalid, 0);
        chk("midrst_bready", hp0_bready, 0);
        chk("midrst_wr_ready", o_wr_ready, 0);
        repeat (3) @(negedge clk);
        #2;
        chk("midrst_err_cleared", o_wr_err, 0);
        chk("midrst_finish", o_write_finish, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rv = '{32'h0000_2000, 23'd128, -1, 1, 32'h0000_2000, 15, 1'b0};
        run_cmd(rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of test, expected completion before 600000");
        $fatal(1, "timeout");
    end

endmodule
